cpu_boot_loader: RTL and testbench

CPU_BOOT_LOADER -- requirements
Module: cpu_boot_loader

---
 rtl/cpu_boot_loader.sv | 108 ++++++++++
 tb/tb_cpu_boot_loader.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_boot_loader.sv
// cpu_boot_loader: streams a program image into instruction memory, then releases the CPU reset.
// Define LOADER_CHECKSUM_EN to require a trailing checksum word before the CPU is released.
module cpu_boot_loader #(
    parameter int          DATA_W      = 32,
    parameter int          ADDR_W      = 32,
    parameter int          DEPTH       = 64,
    parameter int unsigned BASE_ADDR   = 0,
    parameter int          HOLD_CYCLES = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [$clog2(DEPTH+1)-1:0]   word_count,
    input  logic                         in_valid,
    input  logic [DATA_W-1:0]            in_data,
    output logic                         in_ready,
    output logic [DATA_W-1:0]            instruction_initialize_data,
    output logic [ADDR_W-1:0]            instruction_initialize_address,
    output logic                         initialize,
    output logic                         instr_we,
    output logic                         cpu_rst,
    output logic                         busy,
    output logic                         done,
    output logic                         error
);
    localparam int CW        = $clog2(DEPTH + 1);
    localparam int HOLD_LAST = HOLD_CYCLES > 1 ? HOLD_CYCLES - 1 : 0;
    localparam int HW        = HOLD_LAST > 0 ? $clog2(HOLD_LAST + 1) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, SETTLE, RUN, ERR} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, idx, eff;
    logic [HW-1:0]   hold;
    logic            accept, wr, fin, ok;

    assign eff    = word_count > CW'(DEPTH) ? CW'(DEPTH) : word_count;
    assign accept = in_ready && in_valid;

`ifdef LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum;
    // The word following the counted image is the checksum; it is compared, never written.
    assign wr  = accept && idx != cnt;
    assign fin = accept && idx == cnt;
    assign ok  = in_data == sum;
`else
    assign wr  = accept;
    assign fin = accept && idx == cnt - 1'b1;
    assign ok  = 1'b1;
    assign error = 1'b0;
`endif

    always_comb begin
        state_n = state;
        case (state)
            IDLE, RUN, ERR: if (start) state_n = word_count == '0 ? SETTLE : LOAD;
            LOAD:           if (fin) state_n = ok ? SETTLE : ERR;
            SETTLE:         if (hold == HW'(HOLD_LAST)) state_n = RUN;
            default:        state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                          <= IDLE;
            cnt                            <= '0;
            idx                            <= '0;
            hold                           <= '0;
            instruction_initialize_data    <= '0;
            instruction_initialize_address <= '0;
            in_ready                       <= 1'b0;
            initialize                     <= 1'b0;
            instr_we                       <= 1'b0;
            busy                           <= 1'b0;
            done                           <= 1'b0;
            cpu_rst                        <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            sum                            <= '0;
            error                          <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            instr_we   <= wr;
            in_ready   <= state_n == LOAD;
            initialize <= state_n == LOAD || state_n == SETTLE;
            busy       <= state_n == LOAD || state_n == SETTLE;
            done       <= state_n == RUN;
            cpu_rst    <= state_n != RUN;
            hold       <= state == SETTLE ? hold + 1'b1 : '0;
`ifdef LOADER_CHECKSUM_EN
            error      <= state_n == ERR;
            if (wr) sum <= sum + in_data;
`endif
            if (wr) begin
                instruction_initialize_data    <= in_data;
                instruction_initialize_address <= ADDR_W'(BASE_ADDR) + (ADDR_W'(idx) << 2);
                idx                            <= idx + 1'b1;
            end
            if (state != LOAD && state_n == LOAD) begin
                idx <= '0;
                cnt <= eff;
`ifdef LOADER_CHECKSUM_EN
                sum <= '0;
`endif
            end
        end
    end
endmodule

// File: tb/tb_cpu_boot_loader.sv
// tb_cpu_boot_loader: randomized load scenarios; a scoreboard queue of expected writes is
// filled from a simple image model and drained by a monitor watching instr_we.
module tb_cpu_boot_loader;
    localparam int          DATA_W = 32;
    localparam int          ADDR_W = 32;
    localparam int          DEPTH  = 16;
    localparam int          HOLD   = 2;
    localparam int unsigned BASE   = 0;
    localparam int          CW     = $clog2(DEPTH + 1);
`ifdef LOADER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst, start, in_valid;
    logic [CW-1:0]     word_count;
    logic [DATA_W-1:0] in_data;
    logic              in_ready, initialize, instr_we, cpu_rst, busy, done, error;
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;

    cpu_boot_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(BASE),
                      .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .rst(rst), .start(start), .word_count(word_count),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .instruction_initialize_data(data), .instruction_initialize_address(addr),
        .initialize(initialize), .instr_we(instr_we), .cpu_rst(cpu_rst),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  fails  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every write must match the head of the scoreboard; outputs hold between writes.
    initial begin
        logic [31:0] pa, pd;
        bit skip;
        wr_t w;
        skip = 1'b1;
        pa = '0;
        pd = '0;
        forever begin
            @(negedge clk);
            if (instr_we) begin
                check("write_expected", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    w = exp_q.pop_front();
                    check("wr_addr", addr, w.a);
                    check("wr_data", data, w.d);
                end
            end else if (!skip) begin
                check("hold_addr", addr, pa);
                check("hold_data", data, pd);
            end
            pa = addr;
            pd = data;
            skip = rst;
        end
    end

    // seq: 0 = image starting 0x00021020, 0x00844022 then random; 1 = words 1,2,3,...
    // vmode: 0 = in_valid held, 1 = toggling, 2 = random (with stray start pulses)
    task automatic run_load(input int n, input int seq, input int vmode, input int delta,
                            input int abort);
        logic [31:0] words[$];
        logic [31:0] sum;
        int eff, k, acc, cyc, last, npush;
        bit v, rdy, run_ok;
        wr_t w;
        eff = n > DEPTH ? DEPTH : n;
        npush = abort >= 0 && abort < eff ? abort : eff;
        sum = '0;
        for (int i = 0; i < eff; i++) begin
            logic [31:0] x;
            x = seq == 1 ? 32'(i + 1) : i == 0 ? 32'h00021020 : i == 1 ? 32'h00844022 : $urandom;
            words.push_back(x);
            sum += x;
            if (i < npush) begin
                w.a = BASE + 32'(4 * i);
                w.d = x;
                exp_q.push_back(w);
            end
        end
        if (CK && eff > 0) words.push_back(sum + 32'(delta));
        run_ok = !(CK && eff > 0 && delta != 0);
        start = 1'b1;
        word_count = CW'(n);
        tick();
        start = 1'b0;
        check("start_cpu_rst", cpu_rst, 1);
        check("start_busy", busy, 1);
        k = 0;
        acc = 0;
        cyc = 0;
        last = -1;
        while (busy && cyc < 400) begin
            if (abort >= 0 && acc == abort) begin
                in_valid = 1'b1;
                in_data = words[k];
                rst = 1'b1;
                tick();
                rst = 1'b0;
                in_valid = 1'b0;
                check("abort_busy", busy, 0);
                check("abort_in_ready", in_ready, 0);
                check("abort_cpu_rst", cpu_rst, 1);
                check("abort_we", instr_we, 0);
                check("abort_addr", addr, 0);
                check("abort_queue", exp_q.size(), 0);
                return;
            end
            v = k < words.size() ? (vmode == 0 ? 1'b1 : vmode == 1 ? cyc[0] : 1'($urandom)) : 1'b1;
            in_valid = v;
            in_data = k < words.size() ? words[k] : $urandom;
            start = vmode == 2 && $urandom_range(0, 7) == 0;
            word_count = CW'($urandom_range(0, 20));
            rdy = in_ready;
            if (v && rdy) begin
                k++;
                acc++;
                last = cyc;
            end
            tick();
            start = 1'b0;
            cyc++;
        end
        in_valid = 1'b0;
        check("no_timeout", 64'(cyc < 400), 1);
        check("accepted", acc, words.size());
        check("queue_drained", exp_q.size(), 0);
        check("end_done", done, run_ok);
        check("end_error", error, CK && !run_ok);
        check("end_cpu_rst", cpu_rst, !run_ok);
        check("end_in_ready", in_ready, 0);
        check("end_initialize", initialize, 0);
        if (run_ok) check("release_latency", eff > 0 ? cyc - last : cyc, eff > 0 ? HOLD + 1 : HOLD);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        word_count = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_cpu_rst", cpu_rst, 1);
        check("rst_in_ready", in_ready, 0);
        check("rst_initialize", initialize, 0);
        check("rst_we", instr_we, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_addr", addr, 0);
        check("rst_data", data, 0);
        tick();
        check("idle_cpu_rst", cpu_rst, 1);
        run_load(10, 0, 0, 0, -1);
        run_load(10, 0, 1, 0, -1);
        run_load(20, 0, 0, 0, -1);
        run_load(0, 0, 0, 0, -1);
        run_load(10, 0, 0, 0, 3);
        run_load(5, 0, 0, 0, -1);
        if (CK) begin
            run_load(3, 1, 0, 0, -1);
            run_load(3, 1, 0, 1, -1);
        end
        for (int r = 0; r < 10; r++)
            run_load($urandom_range(0, 20), $urandom_range(0, 1), 2, $urandom_range(0, 1), -1);
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
